// File: rtl/pkt_desc_queue_if.sv
// Enqueue/dequeue bus of the packet-descriptor queue manager.
// "priority" is a reserved SystemVerilog keyword, so the enqueue priority field is named prio.
interface pkt_desc_queue_if #(
    parameter int NUM_PORTS = 16,
    parameter int NUM_PRIO  = 8,
    parameter int ADDR_W    = 17,
    parameter int SIZE_W    = 8,
    parameter int PW        = $clog2(NUM_PORTS),
    parameter int QW        = $clog2(NUM_PRIO)
);
    // enqueue side
    logic                          wea;
    logic [PW-1:0]                 dest_port;
    logic [QW-1:0]                 prio;
    logic [ADDR_W-1:0]             write_address;
    logic [SIZE_W-1:0]             w_size;
    logic                          enq_drop;
    // dequeue side
    logic [NUM_PORTS-1:0]          rea;
    logic [NUM_PORTS*NUM_PRIO-1:0] ready;
    logic [NUM_PORTS-1:0]          rd_vld;
    logic [NUM_PORTS*ADDR_W-1:0]   rd_addr;
    logic [NUM_PORTS*SIZE_W-1:0]   rd_size;
    logic [NUM_PORTS*QW-1:0]       rd_priority;
    // per-queue back-pressure
    logic [NUM_PORTS*NUM_PRIO-1:0] full;
    logic [NUM_PORTS*NUM_PRIO-1:0] almost_full;

    modport master (
        output wea, dest_port, prio, write_address, w_size, rea, ready,
        input  enq_drop, rd_vld, rd_addr, rd_size, rd_priority, full, almost_full
    );

    modport slave (
        input  wea, dest_port, prio, write_address, w_size, rea, ready,
        output enq_drop, rd_vld, rd_addr, rd_size, rd_priority, full, almost_full
    );
endinterface

// File: rtl/pkt_desc_queue.sv
// Packet-descriptor queue manager: one circular FIFO per (port, priority),
// a single enqueue per cycle, and an independent dequeue arbiter per port
// (strict priority or round-robin across priorities).
module pkt_desc_queue #(
    parameter int NUM_PORTS  = 16,
    parameter int NUM_PRIO   = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 17,
    parameter int SIZE_W     = 8,
    parameter int AF_LEVEL   = 6,
    parameter int SCHED_MODE = 0,
    parameter int PW         = $clog2(NUM_PORTS),
    parameter int QW         = $clog2(NUM_PRIO)
) (
    input  logic              clk,
    input  logic              rst,
    pkt_desc_queue_if.slave   bus
);
    localparam int NQ = NUM_PORTS * NUM_PRIO;
    localparam int DW = $clog2(DEPTH);
    localparam int CW = DW + 1;
    localparam int EW = PW + QW;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
    } desc_t;

    desc_t         mem    [NQ][DEPTH];
    logic [DW-1:0] wr_ptr [NQ];
    logic [DW-1:0] rd_ptr [NQ];
    logic [CW-1:0] cnt    [NQ];
    logic [CW-1:0] cnt_nxt[NQ];
    logic [QW-1:0] last_q [NUM_PORTS];

    logic [EW-1:0] enq_q;
    logic          enq_ok;
    logic [NQ-1:0] enq_hit;
    logic [NQ-1:0] elig;
    logic [NQ-1:0] pop_hit;
    logic [NQ-1:0] full_nxt;
    logic [NQ-1:0] af_nxt;

    logic [NUM_PORTS-1:0] pop_vld;
    logic [QW-1:0]        pop_q   [NUM_PORTS];
    logic [EW-1:0]        pop_idx [NUM_PORTS];
    desc_t                rd_desc [NUM_PORTS];

    // Queue index is {port, prio}; NUM_PRIO is a power of two so this equals port*NUM_PRIO+prio.
    assign enq_q  = {bus.dest_port, bus.prio};
    // Fullness is judged on the start-of-cycle count, so a same-cycle pop cannot rescue a full queue.
    assign enq_ok = bus.wea && (int'(bus.dest_port) < NUM_PORTS) && (cnt[enq_q] != CW'(DEPTH));

    // Eligibility uses start-of-cycle counts: a same-cycle enqueue into an empty queue is invisible.
    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            elig[i]    = (cnt[i] != '0) && bus.ready[i];
            enq_hit[i] = enq_ok && (enq_q == EW'(i));
        end
    end

    // Per-port arbiter: strict scans q=0 upward; round-robin scans from last_q+1 and wraps.
    always_comb begin
        logic [QW-1:0] qi;
        qi = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pop_vld[p] = 1'b0;
            pop_q[p]   = '0;
            if (bus.rea[p]) begin
                for (int k = 0; k < NUM_PRIO; k++) begin
                    if (SCHED_MODE != 0) qi = last_q[p] + QW'(k + 1);
                    else                 qi = QW'(k);
                    if (!pop_vld[p] && elig[{PW'(p), qi}]) begin
                        pop_vld[p] = 1'b1;
                        pop_q[p]   = qi;
                    end
                end
            end
            pop_idx[p] = {PW'(p), pop_q[p]};
            rd_desc[p] = mem[pop_idx[p]][rd_ptr[pop_idx[p]]];
        end
    end

    // Post-update counts and the flags registered from them.
    always_comb begin
        pop_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            for (int q = 0; q < NUM_PRIO; q++)
                pop_hit[p*NUM_PRIO+q] = pop_vld[p] && (pop_q[p] == QW'(q));
        for (int i = 0; i < NQ; i++) begin
            cnt_nxt[i]  = cnt[i] + CW'(enq_hit[i]) - CW'(pop_hit[i]);
            full_nxt[i] = (cnt_nxt[i] == CW'(DEPTH));
            af_nxt[i]   = (cnt_nxt[i] >= CW'(AF_LEVEL));
        end
    end

    // Descriptor RAM write; contents need no reset since counts gate every read.
    always_ff @(posedge clk) begin
        if (enq_ok) mem[enq_q][wr_ptr[enq_q]] <= desc_t'{bus.write_address, bus.w_size};
    end

    // Queue pointers/counts, arbiter history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            for (int p = 0; p < NUM_PORTS; p++) last_q[p] <= '0;
            bus.rd_vld      <= '0;
            bus.rd_addr     <= '0;
            bus.rd_size     <= '0;
            bus.rd_priority <= '0;
            bus.full        <= '0;
            bus.almost_full <= '0;
            bus.enq_drop    <= 1'b0;
        end else begin
            for (int i = 0; i < NQ; i++) begin
                if (enq_hit[i]) wr_ptr[i] <= wr_ptr[i] + DW'(1);
                if (pop_hit[i]) rd_ptr[i] <= rd_ptr[i] + DW'(1);
                cnt[i] <= cnt_nxt[i];
            end
            bus.full        <= full_nxt;
            bus.almost_full <= af_nxt;
            bus.enq_drop    <= bus.wea && !enq_ok;
            for (int p = 0; p < NUM_PORTS; p++) begin
                bus.rd_vld[p] <= pop_vld[p];
                // Data outputs hold their last value while rd_vld is low.
                if (pop_vld[p]) begin
                    last_q[p]                        <= pop_q[p];
                    bus.rd_addr[p*ADDR_W +: ADDR_W]  <= rd_desc[p].addr;
                    bus.rd_size[p*SIZE_W +: SIZE_W]  <= rd_desc[p].size;
                    bus.rd_priority[p*QW +: QW]      <= pop_q[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_pkt_desc_queue.sv
// Bench for pkt_desc_queue: one strict and one round-robin instance share the
// same stimulus; a queue-based reference model checks both every cycle, with
// table vectors and directed sequences for the multi-cycle corner cases.
module tb_pkt_desc_queue;
    localparam int NP = 16, NQP = 8, DEPTH = 8, AW = 17, SW = 8, AF = 6;
    localparam int PW = 4, QW = 3, NQ = NP * NQP;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          wea;
    logic [PW-1:0] dport;
    logic [QW-1:0] dprio;
    logic [AW-1:0] waddr;
    logic [SW-1:0] wsize;
    logic [NP-1:0] rea;
    logic [NQ-1:0] ready;

    pkt_desc_queue_if #(.NUM_PORTS(NP), .NUM_PRIO(NQP), .ADDR_W(AW), .SIZE_W(SW)) bus_sp ();
    pkt_desc_queue_if #(.NUM_PORTS(NP), .NUM_PRIO(NQP), .ADDR_W(AW), .SIZE_W(SW)) bus_rr ();

    assign bus_sp.wea = wea;   assign bus_rr.wea = wea;
    assign bus_sp.dest_port = dport;   assign bus_rr.dest_port = dport;
    assign bus_sp.prio = dprio;   assign bus_rr.prio = dprio;
    assign bus_sp.write_address = waddr;   assign bus_rr.write_address = waddr;
    assign bus_sp.w_size = wsize;   assign bus_rr.w_size = wsize;
    assign bus_sp.rea = rea;   assign bus_rr.rea = rea;
    assign bus_sp.ready = ready;   assign bus_rr.ready = ready;

    pkt_desc_queue #(.NUM_PORTS(NP), .NUM_PRIO(NQP), .DEPTH(DEPTH), .ADDR_W(AW), .SIZE_W(SW),
                     .AF_LEVEL(AF), .SCHED_MODE(0)) u_sp (.clk(clk), .rst(rst), .bus(bus_sp));
    pkt_desc_queue #(.NUM_PORTS(NP), .NUM_PRIO(NQP), .DEPTH(DEPTH), .ADDR_W(AW), .SIZE_W(SW),
                     .AF_LEVEL(AF), .SCHED_MODE(1)) u_rr (.clk(clk), .rst(rst), .bus(bus_rr));

    // DUT outputs gathered per mode (0 = strict, 1 = round-robin)
    logic [NP-1:0]    a_vld [2];
    logic [NP*AW-1:0] a_addr[2];
    logic [NP*SW-1:0] a_size[2];
    logic [NP*QW-1:0] a_prio[2];
    logic [NQ-1:0]    a_full[2];
    logic [NQ-1:0]    a_af  [2];
    logic             a_drop[2];
    assign a_vld[0] = bus_sp.rd_vld;        assign a_vld[1] = bus_rr.rd_vld;
    assign a_addr[0] = bus_sp.rd_addr;      assign a_addr[1] = bus_rr.rd_addr;
    assign a_size[0] = bus_sp.rd_size;      assign a_size[1] = bus_rr.rd_size;
    assign a_prio[0] = bus_sp.rd_priority;  assign a_prio[1] = bus_rr.rd_priority;
    assign a_full[0] = bus_sp.full;         assign a_full[1] = bus_rr.full;
    assign a_af[0] = bus_sp.almost_full;    assign a_af[1] = bus_rr.almost_full;
    assign a_drop[0] = bus_sp.enq_drop;     assign a_drop[1] = bus_rr.enq_drop;

    // Reference model: one SV queue per (mode, port, prio)
    logic [AW+SW-1:0] mq [2*NQ][$];
    int               last_q [2][NP];
    logic [NP-1:0]    e_vld [2];
    logic [NP*AW-1:0] e_addr[2];
    logic [NP*SW-1:0] e_size[2];
    logic [NP*QW-1:0] e_prio[2];
    logic [NQ-1:0]    e_full[2];
    logic [NQ-1:0]    e_af  [2];
    logic             e_drop[2];

    int nvec = 0, nerr = 0;

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int eq, q, i;
        bit acc;
        logic [AW+SW-1:0] d;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int j = 0; j < NQ; j++) mq[m*NQ+j].delete();
                for (int p = 0; p < NP; p++) last_q[m][p] = 0;
                e_vld[m] = '0; e_addr[m] = '0; e_size[m] = '0; e_prio[m] = '0;
                e_full[m] = '0; e_af[m] = '0; e_drop[m] = 1'b0;
            end else begin
                eq  = int'(dport) * NQP + int'(dprio);
                acc = wea && (mq[m*NQ+eq].size() < DEPTH);
                e_vld[m] = '0;
                for (int p = 0; p < NP; p++) begin
                    if (!rea[p]) continue;
                    for (int k = 0; k < NQP; k++) begin
                        q = (m == 1) ? (last_q[m][p] + 1 + k) % NQP : k;
                        i = p * NQP + q;
                        if (!e_vld[m][p] && ready[i] && mq[m*NQ+i].size() > 0) begin
                            d = mq[m*NQ+i].pop_front();
                            e_vld[m][p] = 1'b1;
                            e_addr[m][p*AW +: AW] = d[AW+SW-1:SW];
                            e_size[m][p*SW +: SW] = d[SW-1:0];
                            e_prio[m][p*QW +: QW] = q[QW-1:0];
                            last_q[m][p] = q;
                        end
                    end
                end
                if (acc) mq[m*NQ+eq].push_back({waddr, wsize});
                e_drop[m] = wea && !acc;
                for (int j = 0; j < NQ; j++) begin
                    e_full[m][j] = (mq[m*NQ+j].size() == DEPTH);
                    e_af[m][j]   = (mq[m*NQ+j].size() >= AF);
                end
            end
        end
    endtask

    // One clock: update the model, take the edge, compare every output of both instances.
    task automatic cycle();
        string mn;
        model_step();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            mn = (m == 0) ? "sp" : "rr";
            chk({mn, ".rd_vld"},      a_vld[m],  e_vld[m]);
            chk({mn, ".rd_addr"},     a_addr[m], e_addr[m]);
            chk({mn, ".rd_size"},     a_size[m], e_size[m]);
            chk({mn, ".rd_priority"}, a_prio[m], e_prio[m]);
            chk({mn, ".full"},        a_full[m], e_full[m]);
            chk({mn, ".almost_full"}, a_af[m],   e_af[m]);
            chk({mn, ".enq_drop"},    a_drop[m], e_drop[m]);
        end
    endtask

    task automatic set_idle();
        wea = 1'b0; rea = '0;
    endtask

    task automatic do_reset();
        set_idle(); rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    endtask

    task automatic enq(int p, int q, int a);
        wea = 1'b1; dport = PW'(p); dprio = QW'(q); waddr = AW'(a); wsize = SW'(a) ^ 8'h5a;
        rea = '0;
        cycle();
        wea = 1'b0;
    endtask

    task automatic pop(int p);
        wea = 1'b0; rea = '0; rea[p] = 1'b1;
        cycle();
    endtask

    function automatic logic [AW-1:0] g_addr(int m, int p); return a_addr[m][p*AW +: AW]; endfunction
    function automatic logic [QW-1:0] g_prio(int m, int p); return a_prio[m][p*QW +: QW]; endfunction

    typedef struct {
        bit            wea;
        logic [AW-1:0] addr;
        bit            rea;
        bit            x_drop, x_af, x_full, x_vld;
        logic [AW-1:0] x_addr;
        logic [QW-1:0] x_prio;
    } vec_t;
    vec_t tbl[18];

    initial begin
        int k;
        int rr_exp[6];
        int sp_exp[6];
        rr_exp = '{3, 0, 3, 0, 3, 0};
        sp_exp = '{0, 0, 0, 3, 3, 3};

        // Fill-and-drop then FIFO drain of queue (3,2): 9 enqueues, 8 pops, one empty pop.
        for (int i = 0; i < 18; i++) begin
            if (i < 9) begin
                tbl[i] = '{wea: 1'b1, addr: AW'(32'h10 + i), rea: 1'b0, x_drop: (i == 8),
                           x_af: (i >= 5), x_full: (i >= 7), x_vld: 1'b0, x_addr: '0, x_prio: '0};
            end else if (i < 17) begin
                k = i - 9;
                tbl[i] = '{wea: 1'b0, addr: '0, rea: 1'b1, x_drop: 1'b0, x_af: (k <= 1),
                           x_full: 1'b0, x_vld: 1'b1, x_addr: AW'(32'h10 + k), x_prio: 3'd2};
            end else begin
                tbl[i] = '{wea: 1'b0, addr: '0, rea: 1'b1, x_drop: 1'b0, x_af: 1'b0,
                           x_full: 1'b0, x_vld: 1'b0, x_addr: AW'(32'h17), x_prio: 3'd2};
            end
        end

        wea = 1'b0; dport = '0; dprio = '0; waddr = '0; wsize = '0; rea = '0; ready = '1;
        rst = 1'b1;
        cycle();
        chk("reset.rd_vld", a_vld[0], '0);
        chk("reset.full", a_full[0], '0);
        do_reset();

        for (int i = 0; i < 18; i++) begin
            wea = tbl[i].wea; dport = 4'd3; dprio = 3'd2; waddr = tbl[i].addr; wsize = SW'(i);
            rea = '0; rea[3] = tbl[i].rea;
            cycle();
            chk("tbl.enq_drop", a_drop[0], tbl[i].x_drop);
            chk("tbl.almost_full", a_af[0][26], tbl[i].x_af);
            chk("tbl.full", a_full[0][26], tbl[i].x_full);
            chk("tbl.rd_vld", a_vld[0][3], tbl[i].x_vld);
            chk("tbl.rd_addr", g_addr(0, 3), tbl[i].x_addr);
            chk("tbl.rd_priority", g_prio(0, 3), tbl[i].x_prio);
        end
        set_idle();

        // Strict priority on port 5, then with queue (5,1) masked off.
        do_reset();
        enq(5, 1, 'h101); enq(5, 4, 'h104); enq(5, 7, 'h107);
        pop(5); chk("sp.first", {a_vld[0][5], g_prio(0, 5)}, {1'b1, 3'd1});
        pop(5); chk("sp.second", {a_vld[0][5], g_prio(0, 5)}, {1'b1, 3'd4});
        pop(5); chk("sp.third", {a_vld[0][5], g_prio(0, 5), g_addr(0, 5)}, {1'b1, 3'd7, 17'h107});
        pop(5); chk("sp.empty", a_vld[0][5], 1'b0);
        enq(5, 1, 'h111); enq(5, 4, 'h114); enq(5, 7, 'h117);
        ready[5*NQP+1] = 1'b0;
        pop(5); chk("sp.mask1", {a_vld[0][5], g_prio(0, 5)}, {1'b1, 3'd4});
        pop(5); chk("sp.mask2", {a_vld[0][5], g_prio(0, 5)}, {1'b1, 3'd7});
        pop(5); chk("sp.masked", a_vld[0][5], 1'b0);
        ready[5*NQP+1] = 1'b1;
        pop(5); chk("sp.unmask", {a_vld[0][5], g_prio(0, 5), g_addr(0, 5)}, {1'b1, 3'd1, 17'h111});

        // Round robin on port 0 with queues (0,0) and (0,3) each holding three entries.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            enq(0, 0, 'h200 + j);
            enq(0, 3, 'h300 + j);
        end
        for (int j = 0; j < 6; j++) begin
            pop(0);
            chk("rr.seq", {a_vld[1][0], g_prio(1, 0)}, {1'b1, QW'(rr_exp[j])});
            chk("rr.sp_seq", {a_vld[0][0], g_prio(0, 0)}, {1'b1, QW'(sp_exp[j])});
        end
        pop(0); chk("rr.drained", a_vld[1][0], 1'b0);

        // Steady-state count 4 on (7,5) with enqueue and pop every cycle.
        do_reset();
        for (int j = 0; j < 4; j++) enq(7, 5, 'h400 + j);
        for (int c = 0; c < 20; c++) begin
            wea = 1'b1; dport = 4'd7; dprio = 3'd5; waddr = AW'('h404 + c); wsize = SW'(c);
            rea = '0; rea[7] = 1'b1;
            cycle();
            chk("wrap.rd", {a_vld[0][7], g_addr(0, 7)}, {1'b1, AW'('h400 + c)});
            chk("wrap.flags", {a_full[0][61], a_af[0][61], a_drop[0]}, 3'b000);
        end
        for (int j = 0; j < 5; j++) begin
            pop(7);
            if (j < 4) chk("wrap.tail", {a_vld[0][7], g_addr(0, 7)}, {1'b1, AW'('h414 + j)});
            else       chk("wrap.end", a_vld[0][7], 1'b0);
        end

        // Enqueue into an empty queue is not seen by the same-cycle dequeue.
        do_reset();
        wea = 1'b1; dport = 4'd9; dprio = 3'd0; waddr = 17'h500; wsize = 8'h33;
        rea = '0; rea[9] = 1'b1;
        cycle();
        chk("empty.same_cycle", a_vld[0][9], 1'b0);
        pop(9);
        chk("empty.next_cycle", {a_vld[0][9], g_addr(0, 9)}, {1'b1, 17'h500});

        // Reset in the middle of traffic.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            wea = 1'b1; dport = PW'(c); dprio = QW'(c); waddr = AW'('h600 + c); wsize = SW'(c);
            rea = '1;
            cycle();
        end
        for (int c = 0; c < 3; c++) enq(1, 1, 'h700 + c);
        rst = 1'b1; wea = 1'b1; rea = '1;
        cycle();
        chk("rst.outputs", {a_vld[0], a_addr[0], a_size[0], a_prio[0], a_drop[0]}, '0);
        chk("rst.flags", {a_full[0], a_af[0]}, '0);
        rst = 1'b0; wea = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rea = '1;
            cycle();
            chk("rst.no_vld", {a_vld[0], a_vld[1]}, '0);
        end
        enq(2, 2, 'h7aa);
        pop(2);
        chk("rst.new_enq", {a_vld[0][2], g_addr(0, 2)}, {1'b1, 17'h7aa});

        // Randomized traffic concentrated on a few queues so they fill, drop and wrap.
        do_reset();
        for (int c = 0; c < 700; c++) begin
            rst   = ($urandom_range(0, 149) == 0);
            wea   = ($urandom_range(0, 3) != 0);
            dport = PW'($urandom_range(0, 3));
            dprio = QW'($urandom_range(0, 3) * 2);
            waddr = AW'($urandom);
            wsize = SW'($urandom);
            rea   = NP'($urandom & $urandom);
            for (int w = 0; w < NQ / 32; w++) ready[w*32 +: 32] = ~($urandom & $urandom & $urandom);
            cycle();
        end
        rst = 1'b0;
        set_idle();
        ready = '1;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/pkt_desc_queue.md
# pkt_desc_queue

Parametrised packet-descriptor queue manager for the shared-SRAM switch. It replaces the fixed 16-port/8-priority addressing path of the cache manager. Accepted packets are enqueued as descriptors (SRAM start address and length) into one FIFO per (destination port, priority). Every output port dequeues independently, choosing among its priorities by strict-priority or round-robin arbitration, and gets per-queue full/almost-full back-pressure.

## Interface
- NUM_PORTS, 16, number of output ports (≥2)
- NUM_PRIO, 8, priority levels per port (≥2, power of 2); priority 0 is highest
- DEPTH, 8, descriptors per queue (power of 2, ≥2)
- ADDR_W, 17, SRAM address width
- SIZE_W, 8, packet length width
- AF_LEVEL, 6, almost_full threshold (1 ≤ AF_LEVEL ≤ DEPTH)
- SCHED_MODE, 0, 0 = strict priority; 1 = round-robin across priorities
- PW = clog2(NUM_PORTS), QW = clog2(NUM_PRIO), derived
- One clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wea  in  1  enqueue strobe
- dest_port  in  PW  target port of the descriptor
- priority  in  QW  priority of the descriptor
- write_address  in  ADDR_W  SRAM start address of the packet
- w_size  in  SIZE_W  packet length
- enq_drop  out  1  one-cycle pulse: last enqueue was rejected (queue full)
- rea  in  NUM_PORTS  per-port dequeue request
- ready  in  NUM_PORTS*NUM_PRIO  eligibility mask; bit p*NUM_PRIO+q enables queue (p,q)
- rd_vld  out  NUM_PORTS  descriptor valid, per port
- rd_addr  out  NUM_PORTS*ADDR_W  dequeued address, port p at slice p
- rd_size  out  NUM_PORTS*SIZE_W  dequeued length
- rd_priority  out  NUM_PORTS*QW  priority of the dequeued descriptor
- full  out  NUM_PORTS*NUM_PRIO  queue count == DEPTH
- almost_full  out  NUM_PORTS*NUM_PRIO  queue count ≥ AF_LEVEL

## Operation
- **Storage:** NUM_PORTS*NUM_PRIO circular FIFOs. Each has a wr_ptr and rd_ptr (clog2(DEPTH) bits, wrap modulo DEPTH) and a count (clog2(DEPTH)+1 bits).
- **Enqueue:** with wea=1, target queue (dest_port, priority). If count < DEPTH, write the descriptor at wr_ptr and increment wr_ptr. Otherwise drop it: no state change, and enq_drop=1 on the next cycle. At most one enqueue per cycle.
- **Eligibility:** queue (p,q) is eligible in a cycle when count > 0 at the start of the cycle and ready bit (p,q) = 1.
- **Dequeue:** for each port p with rea[p]=1 and at least one eligible queue, select one queue, pop it (increment rd_ptr), and register the descriptor onto the outputs. No eligible queue gives rd_vld[p]=0. rea[p]=0 gives rd_vld[p]=0 and no pop.
- **Strict mode (SCHED_MODE=0):** the eligible queue with the lowest q wins.
- **Round-robin mode (SCHED_MODE=1):** each port holds last_q (reset 0). The search starts at last_q+1 mod NUM_PRIO. The first eligible queue wins, and last_q is updated to it on each pop.
- **Same-cycle enqueue and pop, same queue:** both take effect and count is unchanged.
- **Full queue:** an enqueue is dropped even if the same queue pops in that cycle; fullness uses the start-of-cycle count.
- **Empty queue:** an enqueue is not visible to the same-cycle dequeue. It becomes eligible the next cycle.
- **Status flags:** full and almost_full are registered from the post-update count.
- **Reset:** clears all counts, pointers and last_q. The descriptor RAM contents are don't-care.
- **Reset mid-operation:** the queued descriptors are discarded.

## Timing
- **Output reset values:** rd_vld=0, rd_addr=0, rd_size=0, rd_priority=0, full=0, almost_full=0, enq_drop=0.
- **Dequeue latency:** rea sampled at edge N gives the descriptor on the outputs after edge N, valid for exactly one cycle.
- **Throughput:** one pop per port per cycle, so ports pop fully in parallel.
- **Hold behaviour:** rd_addr, rd_size and rd_priority hold their last value while rd_vld=0.
- **Flag latency:** full and almost_full update one cycle after the enqueue or pop that changes the count.
- **Back-to-back dequeue:** with rea held high on a queue of k entries, rd_vld stays high for k consecutive cycles and then drops.

## Test plan
- **Fill and drop:** reset, then 9 enqueues to (3,2) with addresses 0x10..0x18 and DEPTH=8. Required: almost_full(3,2) rises after the 6th enqueue, full after the 8th, and the 9th gives enq_drop=1 with count staying 8.
- **FIFO order:** rea[3]=1 for 8 cycles on that queue. Required: rd_addr = 0x10..0x17 in order, rd_priority=2, then rd_vld=0.
- **Strict priority:** queues (5,1), (5,4) and (5,7) each hold one entry, with ready all ones and SCHED_MODE=0. Required: pops come out as priorities 1, 4, 7. Clearing ready bit (5,1) first gives 4, 7 and then 1 only after it is re-enabled.
- **Round robin:** SCHED_MODE=1, with queues (0,0) and (0,3) each holding 3 entries. Required: the priority sequence is 3,0,3,0,3,0.
- **Wrap and concurrency:** keep a queue at steady-state count 4 while enqueuing and popping every cycle for 20 cycles. Required: count stays 4, pointers wrap correctly and descriptors stay in order. A same-cycle enqueue into an empty queue gives no rd_vld that cycle and rd_vld on the following cycle.
- **Reset mid-traffic:** assert rst during a burst. Required: the cycle after, all outputs are at their reset values and rea yields rd_vld=0 until a new enqueue.
